// File: rtl/turn_sequencer_p.sv
// turn_sequencer_p: paper-soccer turn sequencer; alternates local/remote framed turns over a char link.
// Ports: clk/rst (async active-low) | game_start, first_move, game_abort: game control
//        rx_data/rx_valid: remote chars | my_turn, move_valid, move_dir, move_again: local moves
//        upd_dir/upd_valid/upd_src/upd_done: board-update handshake | tx_data/tx_wr/tx_full: TX buffer
//        move_count, turn_timeout, proto_err: status
module turn_sequencer_p #(
   parameter int DIR_W = 3,
   parameter int NUM_DIRS = 8,
   parameter int CHAR_W = 8,
   parameter int ASCII_BASE = 48,
   parameter logic [CHAR_W-1:0] OPEN_CH = 8'h7B,
   parameter logic [CHAR_W-1:0] CLOSE_CH = 8'h7D,
   parameter logic [CHAR_W-1:0] EOL_CH = 8'h0A,
   parameter int MAX_MOVES = 16,
   parameter int TURN_CYCLES = 50000000,
   localparam int MC_W = $clog2(MAX_MOVES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              game_start,
   input  logic              first_move,
   input  logic              game_abort,
   input  logic [CHAR_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              my_turn,
   input  logic              move_valid,
   input  logic [DIR_W-1:0]  move_dir,
   input  logic              move_again,
   output logic [DIR_W-1:0]  upd_dir,
   output logic              upd_valid,
   output logic              upd_src,
   input  logic              upd_done,
   output logic [CHAR_W-1:0] tx_data,
   output logic              tx_wr,
   input  logic              tx_full,
   output logic [MC_W-1:0]   move_count,
   output logic              turn_timeout,
   output logic              proto_err
);
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   typedef enum logic [3:0] {IDLE, R_OPEN, R_MOVE, R_UPD, R_EOL, L_OPEN, L_WAIT, L_UPD, L_CLOSE, L_EOL} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, tick;
   logic [MC_W-1:0] move_count_q, move_count_d;
   logic [DIR_W-1:0] upd_dir_q, upd_dir_d;
   logic [CHAR_W-1:0] tx_data_q, tx_data_d, rx_off;
   logic upd_valid_q, upd_valid_d, upd_src_q, upd_src_d, tx_wr_q, tx_wr_d;
   logic turn_timeout_q, turn_timeout_d, proto_err_q, proto_err_d, again_q, again_d;
   logic expired, rx_dir_ok, loc_try, accept, more;
   // unsigned CHAR_W-wide offset: chars below ASCII_BASE wrap high and fail the range test
   assign rx_off = rx_data - CHAR_W'(ASCII_BASE);
   assign rx_dir_ok = int'(rx_off) < NUM_DIRS;
   assign expired = timer_q == TW'(TURN_CYCLES - 1);
   assign tick = expired ? timer_q : timer_q + TW'(1);
   assign my_turn = (state_q == L_WAIT) && !tx_full && !expired;
   assign loc_try = my_turn && move_valid;
   assign accept = loc_try && (int'(move_dir) < NUM_DIRS);
   assign more = again_q && (move_count_q < MC_W'(MAX_MOVES)) && !expired;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         move_count_q <= '0;
         upd_dir_q <= '0;
         tx_data_q <= '0;
         upd_valid_q <= 1'b0;
         upd_src_q <= 1'b0;
         tx_wr_q <= 1'b0;
         turn_timeout_q <= 1'b0;
         proto_err_q <= 1'b0;
         again_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         move_count_q <= move_count_d;
         upd_dir_q <= upd_dir_d;
         tx_data_q <= tx_data_d;
         upd_valid_q <= upd_valid_d;
         upd_src_q <= upd_src_d;
         tx_wr_q <= tx_wr_d;
         turn_timeout_q <= turn_timeout_d;
         proto_err_q <= proto_err_d;
         again_q <= again_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (game_start) state_d = first_move ? L_OPEN : R_OPEN;
         R_OPEN:  if (rx_valid && rx_data == OPEN_CH) state_d = R_MOVE;
         R_MOVE:  if (rx_valid) state_d = rx_dir_ok ? R_UPD : (rx_data == CLOSE_CH) ? R_EOL : R_MOVE;
         R_UPD:   if (upd_done) state_d = R_MOVE;
         R_EOL:   if (rx_valid && rx_data == EOL_CH) state_d = L_OPEN;
         L_OPEN:  if (!tx_full) state_d = L_WAIT;
         L_WAIT:  state_d = expired ? L_CLOSE : accept ? L_UPD : L_WAIT;
         L_UPD:   if (upd_done) state_d = more ? L_WAIT : L_CLOSE;
         L_CLOSE: if (!tx_full) state_d = L_EOL;
         L_EOL:   if (!tx_full) state_d = R_OPEN;
         default: state_d = IDLE;
      endcase
      if (game_abort) state_d = IDLE;
   end
   always_comb begin
      timer_d = timer_q;
      move_count_d = move_count_q;
      upd_dir_d = upd_dir_q;
      tx_data_d = tx_data_q;
      upd_valid_d = upd_valid_q;
      upd_src_d = upd_src_q;
      again_d = again_q;
      tx_wr_d = 1'b0;
      turn_timeout_d = 1'b0;
      proto_err_d = 1'b0;
      case (state_q)
         R_OPEN: proto_err_d = rx_valid && rx_data != OPEN_CH;
         R_MOVE: begin
            proto_err_d = rx_valid && !rx_dir_ok && rx_data != CLOSE_CH;
            if (rx_valid && rx_dir_ok) begin
               upd_valid_d = 1'b1;
               upd_dir_d = rx_off[DIR_W-1:0];
               upd_src_d = 1'b1;
            end
         end
         R_UPD: begin
            proto_err_d = rx_valid;
            upd_valid_d = upd_valid_q && !upd_done;
         end
         R_EOL: proto_err_d = rx_valid && rx_data != EOL_CH;
         L_OPEN: if (!tx_full) begin
            tx_wr_d = 1'b1;
            tx_data_d = OPEN_CH;
            timer_d = '0;
            move_count_d = '0;
         end
         L_WAIT: begin
            timer_d = tick;
            turn_timeout_d = expired;
            proto_err_d = loc_try && !accept;
            if (accept) begin
               tx_wr_d = 1'b1;
               tx_data_d = CHAR_W'(move_dir) + CHAR_W'(ASCII_BASE);
               upd_valid_d = 1'b1;
               upd_dir_d = move_dir;
               upd_src_d = 1'b0;
               move_count_d = move_count_q + MC_W'(1);
               again_d = move_again;
            end
         end
         L_UPD: begin
            timer_d = tick;
            upd_valid_d = upd_valid_q && !upd_done;
            turn_timeout_d = upd_done && expired;
         end
         L_CLOSE: if (!tx_full) begin
            tx_wr_d = 1'b1;
            tx_data_d = CLOSE_CH;
         end
         L_EOL: if (!tx_full) begin
            tx_wr_d = 1'b1;
            tx_data_d = EOL_CH;
         end
         default: ;
      endcase
      // abort wins over everything: drop any pending handshake, write or pulse
      if (game_abort) begin
         tx_wr_d = 1'b0;
         upd_valid_d = 1'b0;
         turn_timeout_d = 1'b0;
         proto_err_d = 1'b0;
      end
   end
   assign upd_dir = upd_dir_q;
   assign upd_valid = upd_valid_q;
   assign upd_src = upd_src_q;
   assign tx_data = tx_data_q;
   assign tx_wr = tx_wr_q;
   assign move_count = move_count_q;
   assign turn_timeout = turn_timeout_q;
   assign proto_err = proto_err_q;
endmodule
